// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle sequencer: state encodings, memory
// command codes, PC-select values and the syscall code that stops the machine.
package multicycle_ctrl_pkg;

  localparam int W_STATE   = 3;
  localparam int W_MEM_CMD = 2;
  localparam int W_PC_SRC  = 1;
  localparam int W_WAIT    = 8;

  localparam int SYSCALL_EXIT = 10;

  typedef enum logic [W_STATE-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  typedef enum logic [W_MEM_CMD-1:0] {
    MEM_CMD_NONE  = 2'b00,
    MEM_CMD_READ  = 2'b01,
    MEM_CMD_WRITE = 2'b10
  } mem_cmd_t;

  localparam logic [W_PC_SRC-1:0] PC_SEL_SEQ    = 1'b0;
  localparam logic [W_PC_SRC-1:0] PC_SEL_TARGET = 1'b1;

  // States in which an instruction is in flight and the cycle counter runs.
  function automatic logic is_active(input state_t s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
           (s == ST_MEM)   || (s == ST_WB);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the cycle
// in which the count would reach the timeout limit without the access ending.
module mc_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  logic [W_WAIT-1:0] wait_cnt;
  logic              stalled;

  assign stalled = active && !mem_ready;
  // A ready in the limit cycle suppresses the timeout because stalled drops.
  assign timeout = stalled && (wait_cnt == W_WAIT'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (stalled && !timeout) begin
      wait_cnt <= wait_cnt + W_WAIT'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// over a shared memory port and gates every architectural write enable.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int W_CPU       = 32,
  parameter int W_CNT       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dec_load,
  input  logic                 dec_store,
  input  logic                 dec_branch,
  input  logic                 dec_jump,
  input  logic                 dec_syscall,
  input  logic                 dec_reg_wen,
  input  logic [W_CPU-1:0]     syscall_code,
  input  logic                 mem_ready,
  output logic                 ir_wen,
  output logic                 pc_wen,
  output logic [W_PC_SRC-1:0]  pc_sel,
  output logic                 mem_req,
  output logic [W_MEM_CMD-1:0] mem_cmd,
  output logic                 mem_ifetch,
  output logic                 reg_wen,
  output logic [W_STATE-1:0]   state,
  output logic                 halted,
  output logic                 fault,
  output logic [W_CNT-1:0]     cycles,
  output logic [W_CNT-1:0]     instret
);

  state_t   state_q;
  state_t   state_next;
  mem_cmd_t cmd;
  logic     retire;
  logic     mem_active;
  logic     timeout;
  logic     is_exit;

  assign state      = state_q;
  assign mem_cmd    = cmd;
  assign mem_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign is_exit    = (syscall_code == W_CPU'(SYSCALL_EXIT));

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .active    (mem_active),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      halted  <= 1'b0;
      fault   <= 1'b0;
      cycles  <= '0;
      instret <= '0;
    end else begin
      state_q <= state_next;
      halted  <= (state_next == ST_HALT);
      fault   <= (state_next == ST_FAULT);
      if (is_active(state_q)) begin
        cycles <= cycles + W_CNT'(1);
      end
      if (retire) begin
        instret <= instret + W_CNT'(1);
      end
    end
  end

  // Enables are decoded from the current state only, so an asynchronous reset
  // drops every request in the same instant.
  always_comb begin
    state_next = state_q;
    ir_wen     = 1'b0;
    pc_wen     = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    mem_req    = 1'b0;
    cmd        = MEM_CMD_NONE;
    mem_ifetch = 1'b0;
    reg_wen    = 1'b0;
    retire     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_req    = 1'b1;
        cmd        = MEM_CMD_READ;
        mem_ifetch = 1'b1;
        if (mem_ready) begin
          ir_wen     = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_FAULT;
        end
      end

      ST_DECODE: begin
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        if (dec_syscall) begin
          if (is_exit) begin
            state_next = ST_HALT;
          end else begin
            pc_wen     = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
        end else if (dec_load && dec_store) begin
          state_next = ST_FAULT;
        end else if (dec_branch || dec_jump) begin
          pc_wen     = 1'b1;
          pc_sel     = PC_SEL_TARGET;
          reg_wen    = dec_reg_wen;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (dec_load || dec_store) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        cmd     = dec_store ? MEM_CMD_WRITE : MEM_CMD_READ;
        if (mem_ready) begin
          if (dec_store) begin
            pc_wen     = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timeout) begin
          state_next = ST_FAULT;
        end
      end

      ST_WB: begin
        reg_wen    = dec_reg_wen;
        pc_wen     = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end

      ST_HALT, ST_FAULT: begin
        state_next = state_q;
      end

      default: begin
        state_next = ST_FAULT;
      end
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- FSM sequencer that turns the existing single-cycle datapath (fetch, decode, regfile, ALU, memory) into a multicycle machine with a shared memory port.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Gates all architectural write enables.
- Stalls on memory ready, halts on SYSCALL 10, and faults on memory timeout or illegal decode.
- Sits between DECODE outputs and the regfile/memory/PC write ports in the CPU top.

Parameters:
- W_CPU, 32, datapath width (syscall code input)
- W_CNT, 32, width of the cycle and retired-instruction counters
- MEM_TIMEOUT, 15, max consecutive not-ready cycles in FETCH/MEM before FAULT (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  pulse; leaves IDLE
- dec_load  in  1  decoded instruction is a load
- dec_store  in  1  decoded instruction is a store
- dec_branch  in  1  decoded branch (taken/not resolved in fetch)
- dec_jump  in  1  decoded j/jal/jr
- dec_syscall  in  1  decoded SYSCALL
- dec_reg_wen  in  1  decoder's register write request
- syscall_code  in  W_CPU  rd1 ($v0) value
- mem_ready  in  1  memory completes access this cycle
- ir_wen  out  1  latch instruction register
- pc_wen  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = fetch-computed branch/jump target
- mem_req  out  1  memory access request
- mem_cmd  out  2  00 none, 01 read, 10 write
- mem_ifetch  out  1  access is instruction fetch (address = PC)
- reg_wen  out  1  regfile write enable
- state  out  3  current state encoding
- halted  out  1  in HALT
- fault  out  1  in FAULT
- cycles  out  W_CNT  active-cycle counter
- instret  out  W_CNT  retired-instruction counter

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - All outputs 0, counters 0, wait counter 0.
  - mem_req drops immediately, including mid-access.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: start=1 -> FETCH next cycle; otherwise hold.
- FETCH:
  - mem_req=1, mem_cmd=01, mem_ifetch=1.
  - When mem_ready=1: ir_wen=1 same cycle (combinational), -> DECODE.
- DECODE: one cycle, no enables, -> EXEC.
- EXEC, priority order:
  - dec_syscall:
    - syscall_code==10 -> HALT.
    - Otherwise retire as NOP: pc_wen=1, pc_sel=0, -> FETCH.
  - dec_load and dec_store both 1 -> FAULT.
  - dec_branch or dec_jump: pc_wen=1, pc_sel=1, reg_wen=dec_reg_wen (jal link), retire, -> FETCH.
  - dec_load or dec_store -> MEM.
  - Otherwise -> WB.
- MEM:
  - mem_req=1, mem_cmd=01 (load) or 10 (store), mem_ifetch=0.
  - On mem_ready, load: -> WB.
  - On mem_ready, store: pc_wen=1, pc_sel=0, retire, -> FETCH.
- WB: reg_wen=dec_reg_wen, pc_wen=1, pc_sel=0, retire, -> FETCH.
- HALT, FAULT: sticky. start ignored; only reset exits. halted/fault are registered from state.
- Retire: instret += 1 on the retiring edge. Wraps modulo 2^W_CNT.
- cycles: += 1 every cycle state is in FETCH..WB. Wraps.
- Wait counter:
  - Increments each cycle in FETCH/MEM with mem_ready=0.
  - Clears on mem_ready or state exit.
  - Reaching MEM_TIMEOUT -> FAULT next edge, mem_req deasserted in FAULT.
  - mem_ready in the same cycle as the limit wins; no fault.
- Enable gating:
  - ir_wen, pc_wen, reg_wen and mem_req are never asserted outside the states listed above.
  - At most one of ir_wen/reg_wen is asserted per cycle.
- Latency with mem_ready tied 1:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/jump/non-exit syscall: 3 cycles.

Decomposition:
- Shared defines header, alongside existing `W_MEM_CMD/`W_PC_SRC definitions:
  - State encodings (ST_IDLE..ST_FAULT)
  - MEM_CMD_NONE/READ/WRITE
  - SYSCALL_EXIT=10
  - W_STATE=3
- Natural sub-module: mc_wait_timer (wait counter + timeout compare).
- FSM and perf counters stay in multicycle_ctrl.

Test Plan:
1. Reset, start, ALU op (dec_reg_wen=1), mem_ready=1 -> states 1,2,3,5. ir_wen in cycle 1, reg_wen+pc_wen in cycle 4. instret=1, cycles=4.
2. Load with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_cmd=01, mem_ifetch=0. WB follows; total 8 cycles, instret=1.
3. Store then branch -> store retires from MEM with no reg_wen. Branch pc_sel=1 in EXEC; instret=2 after 7 cycles.
4. SYSCALL, syscall_code=1, then SYSCALL, code=10 -> first retires, second enters HALT. halted=1; instret=1; start ignored.
5. mem_ready held 0 in FETCH, MEM_TIMEOUT=15 -> FAULT after 15 wait cycles, mem_req=0, fault=1. dec_load&dec_store in EXEC also -> FAULT.
6. rst asserted mid-MEM (asynchronous, off clock edge) -> mem_req falls immediately, state=0, counters 0. start restarts cleanly.
